// File: rtl/mfsk_tx.sv
// rtl/mfsk_tx.sv - M-ary FSK modulator with valid/ready input, optional preamble and done pulse
//
// Accepts one DATA_W-bit word on an in_valid/in_ready handshake and sends it
// as a 1-bit square-wave tone stream. Each symbol is BPS bits wide, lasts
// SYM_CYCLES clocks and uses a tone of half-period BASE_HALF + s*STEP_HALF.
// An optional preamble of PRE_SYMS symbols (0, M-1, 0, M-1, ...) precedes
// the data symbols, which are sent MSB group first.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       asynchronous active-low reset
//   in_valid  in   1       in_data is valid
//   in_ready  out  1       block can accept a word (IDLE only)
//   in_data   in   DATA_W  word to transmit, sampled at handshake
//   fsk_out   out  1       modulated tone output
//   busy      out  1       frame in progress (preamble or data)
//   sym_val   out  BPS     symbol currently being sent, 0 when idle
//   tx_done   out  1       one-cycle pulse in the first IDLE cycle after a frame

module mfsk_tx #(
  parameter int DATA_W     = 16,
  parameter int BPS        = 2,
  parameter int SYM_CYCLES = 256,
  parameter int BASE_HALF  = 8,
  parameter int STEP_HALF  = 4,
  parameter int PRE_SYMS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              fsk_out,
  output logic              busy,
  output logic [BPS-1:0]    sym_val,
  output logic              tx_done
);

  localparam int M      = 2 ** BPS;
  localparam int NSYM   = DATA_W / BPS;
  localparam int HMAX   = BASE_HALF + (M - 1) * STEP_HALF;
  localparam int MAXN   = (PRE_SYMS > NSYM) ? PRE_SYMS : NSYM;
  localparam int SYM_W  = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int TONE_W = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int IDX_W  = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               fsk_q, fsk_d;
  logic               done_q, done_d;

  logic [BPS-1:0]     cur_sym;
  logic [31:0]        half_m1;
  logic               sym_last;

  // Current symbol: the preamble alternates 0 / M-1 on the index LSB; data
  // symbols come from the top of a word register that shifts left per symbol.
  always_comb begin
    cur_sym = '0;
    case (state_q)
      ST_PRE:  cur_sym = idx_q[0] ? {BPS{1'b1}} : {BPS{1'b0}};
      ST_DATA: cur_sym = word_q[DATA_W-1 -: BPS];
      default: cur_sym = '0;
    endcase
  end

  // Terminal count of the tone counter for the current symbol: H(s) - 1.
  assign half_m1  = 32'(BASE_HALF - 1) + 32'(cur_sym) * 32'(STEP_HALF);
  assign sym_last = (sym_cnt_q == SYM_W'(SYM_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    tone_cnt_d = tone_cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    fsk_d      = fsk_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fsk_d      = 1'b0;
        tone_cnt_d = '0;
        sym_cnt_d  = '0;
        idx_d      = '0;
        if (in_valid) begin
          word_d  = in_data;
          state_d = (PRE_SYMS > 0) ? ST_PRE : ST_DATA;
        end
      end

      ST_PRE, ST_DATA: begin
        if (32'(tone_cnt_q) == half_m1) begin
          fsk_d      = ~fsk_q;
          tone_cnt_d = '0;
        end else begin
          tone_cnt_d = tone_cnt_q + TONE_W'(1);
        end

        if (sym_last) begin
          // The symbol boundary wins over a toggle on the same edge: every
          // symbol restarts in phase with fsk_out low.
          sym_cnt_d  = '0;
          tone_cnt_d = '0;
          fsk_d      = 1'b0;
          idx_d      = idx_q + IDX_W'(1);
          if (state_q == ST_PRE) begin
            if (idx_q == IDX_W'(PRE_SYMS - 1)) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end
          end else begin
            word_d = word_q << BPS;
            if (idx_q == IDX_W'(NSYM - 1)) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        fsk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      tone_cnt_q <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      fsk_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      fsk_q      <= fsk_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign sym_val  = cur_sym;
  assign fsk_out  = fsk_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_mfsk_tx.sv
// tb/tb_mfsk_tx.sv - scoreboard bench for mfsk_tx (default, no-preamble and BPS=1 configurations)

module tb_mfsk_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v_def, v_np, v_b1;
  logic [15:0] d_def, d_np;
  logic [7:0]  d_b1;
  logic        r_def, f_def, b_def, t_def;
  logic        r_np,  f_np,  b_np,  t_np;
  logic        r_b1,  f_b1,  b_b1,  t_b1;
  logic [1:0]  s_def, s_np;
  logic [0:0]  s_b1;

  mfsk_tx u_def (
    .clk(clk), .rst(rst), .in_valid(v_def), .in_ready(r_def), .in_data(d_def),
    .fsk_out(f_def), .busy(b_def), .sym_val(s_def), .tx_done(t_def)
  );

  mfsk_tx #(.PRE_SYMS(0)) u_np (
    .clk(clk), .rst(rst), .in_valid(v_np), .in_ready(r_np), .in_data(d_np),
    .fsk_out(f_np), .busy(b_np), .sym_val(s_np), .tx_done(t_np)
  );

  mfsk_tx #(.DATA_W(8), .BPS(1), .SYM_CYCLES(64), .PRE_SYMS(0)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(v_b1), .in_ready(r_b1), .in_data(d_b1),
    .fsk_out(f_b1), .busy(b_b1), .sym_val(s_b1), .tx_done(t_b1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // kind 0: symbol (a = sym_val, b = rising edges); kind 1: frame end (a = busy cycles);
  // kind 2: idle gap before the next frame (a = idle cycles)
  typedef struct {
    int kind;
    int a;
    int b;
  } exp_t;
  exp_t exp_q[$];

  // Hand-computed rising-edge counts per symbol value.
  int def_r[4] = '{16, 11, 8, 6};
  int b1_r[2]  = '{4, 3};

  int sel = 0;
  logic       m_busy, m_fsk, m_done, m_ready;
  logic [1:0] m_val;
  int         symc;

  always_comb begin
    m_busy = b_def; m_fsk = f_def; m_done = t_def; m_ready = r_def; m_val = s_def; symc = 256;
    case (sel)
      1: begin m_busy = b_np; m_fsk = f_np; m_done = t_np; m_ready = r_np; m_val = s_np; symc = 256; end
      2: begin m_busy = b_b1; m_fsk = f_b1; m_done = t_b1; m_ready = r_b1; m_val = {1'b0, s_b1}; symc = 64; end
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  int   cyc = 0, cur_sym = 0, rises = 0, fsk0 = 0, unstable = 0, busy_len = 0, idle_run = 0;
  logic prev_fsk = 1'b0, prev_busy = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0; busy_len = 0; idle_run = 0; prev_fsk = 1'b0; prev_busy = 1'b0;
    end else begin
      if (m_busy && !prev_busy && exp_q.size() > 0 && exp_q[0].kind == 2) begin
        e = exp_q.pop_front();
        check("idle_gap", idle_run, e.a);
      end
      if (m_busy) begin
        if (cyc == 0) begin
          cur_sym = int'(m_val); rises = 0; fsk0 = int'(m_fsk); unstable = 0;
        end else begin
          if (int'(m_val) != cur_sym) unstable = 1;
          if (!prev_fsk && m_fsk) rises++;
        end
        cyc++; busy_len++; idle_run = 0;
        if (cyc == symc) begin
          cyc = 0;
          if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_symbol: got sym %0d expected none (t=%0t)", cur_sym, $time);
          end else begin
            e = exp_q.pop_front();
            check("sym_val", cur_sym, e.a);
            check("sym_rises", rises, e.b);
            check("sym_start_fsk", fsk0, 0);
            check("sym_stable", unstable, 0);
          end
        end
      end else begin
        idle_run++;
      end
      if (m_done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_tx_done: got pulse expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_len", busy_len, e.a);
          check("done_sym_pos", cyc, 0);
          check("done_outputs", int'({m_busy, m_ready, m_fsk, m_val}), 5'b01000);
        end
        busy_len = 0;
      end
      prev_fsk  = m_fsk;
      prev_busy = m_busy;
    end
  end

  task automatic push_frame(input int s, input logic [15:0] w);
    exp_t x;
    int sy;
    if (s == 0) begin
      for (int k = 0; k < 4; k++) begin
        sy = (k % 2 == 1) ? 3 : 0;
        x.kind = 0; x.a = sy; x.b = def_r[sy]; exp_q.push_back(x);
      end
    end
    if (s == 2) begin
      for (int k = 0; k < 8; k++) begin
        sy = int'((w >> (7 - k)) & 16'h1);
        x.kind = 0; x.a = sy; x.b = b1_r[sy]; exp_q.push_back(x);
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        sy = int'((w >> (14 - 2 * k)) & 16'h3);
        x.kind = 0; x.a = sy; x.b = def_r[sy]; exp_q.push_back(x);
      end
    end
    x.kind = 1; x.b = 0;
    x.a = (s == 0) ? 3072 : ((s == 1) ? 2048 : 512);
    exp_q.push_back(x);
  endtask

  task automatic start(input int s, input logic [15:0] w);
    int t;
    @(negedge clk);
    case (s)
      0: begin d_def = w; v_def = 1'b1; end
      1: begin d_np  = w; v_np  = 1'b1; end
      default: begin d_b1 = w[7:0]; v_b1 = 1'b1; end
    endcase
    t = 0;
    while (!m_ready && t < 5000) begin @(negedge clk); t++; end
    if (!m_ready) check("start_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    v_def = 1'b0; v_np = 1'b0; v_b1 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < budget) begin @(negedge clk); t++; end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t g;
    int t, bcnt;
    rst = 1'b0;
    v_def = 1'b0; v_np = 1'b0; v_b1 = 1'b0;
    d_def = '0; d_np = '0; d_b1 = '0;

    // 1) reset with in_valid held high
    v_def = 1'b1; d_def = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(r_def), 1);
    check("rst_fsk_out", int'(f_def), 0);
    check("rst_busy", int'(b_def), 0);
    check("rst_tx_done", int'(t_def), 0);
    check("rst_sym_val", int'(s_def), 0);
    v_def = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_accept", int'(b_def), 0);

    // 2) tone plan, no preamble
    sel = 1;
    push_frame(1, 16'h1B1B);
    start(1, 16'h1B1B);
    drain(2300);

    // 3) preamble with defaults
    sel = 0;
    push_frame(0, 16'h0000);
    start(0, 16'h0000);
    drain(3300);

    // 4) in_valid held high across two frames
    sel = 1;
    push_frame(1, 16'hE4E4);
    g.kind = 2; g.a = 1; g.b = 0; exp_q.push_back(g);
    push_frame(1, 16'h33CC);
    @(negedge clk);
    d_np = 16'hE4E4; v_np = 1'b1;
    t = 0;
    while (!b_np && t < 20) begin @(negedge clk); t++; end
    check("hs_a_started", int'(b_np), 1);
    d_np = 16'h33CC;
    t = 0;
    while (!t_np && t < 2200) begin @(negedge clk); t++; end
    check("hs_a_done_seen", int'(t_np), 1);
    check("hs_ready_in_done", int'(r_np), 1);
    @(posedge clk);
    #1;
    v_np = 1'b0;
    drain(2300);

    // 5) reset in the middle of a frame
    sel = 0;
    push_frame(0, 16'hFFFF);
    start(0, 16'hFFFF);
    repeat (1000) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", int'(b_def), 0);
    check("midrst_in_ready", int'(r_def), 1);
    check("midrst_fsk_out", int'(f_def), 0);
    check("midrst_sym_val", int'(s_def), 0);
    check("midrst_tx_done", int'(t_def), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (b_def || t_def) bcnt++;
    end
    check("midrst_residual", bcnt, 0);
    check("midrst_ready_after", int'(r_def), 1);

    // 6) BPS=1, 8-bit word, 64-cycle symbols
    sel = 2;
    push_frame(2, 16'h00A5);
    start(2, 16'h00A5);
    drain(700);

    repeat (5) @(negedge clk);
    check("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
